fsm_pattern_detect: RTL and testbench

Parametrised serial pattern detector, successor to the fixed "Hello" welcome FSM. Scans a byte/character stream qualified by a valid strobe for a compile-time pattern of any length. Mismatches fall back through partial matches (prefix/suffix fallback), so preceding junk cannot hide a match, e.g. "HHello". Outputs are:
- a one-cycle match pulse;
- a toggling LED;
- a saturating match counter;
- the current match progress.

It sits directly behind the character source (UART RX or testbench stream) in the welcome-demo designs.

---
 rtl/fsm_pattern_detect.sv | 130 +++++++++++++
 tb/tb_fsm_pattern_detect.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_detect.sv
// Serial pattern detector with KMP-style fallback: scans a valid-qualified character
// stream for a compile-time pattern and reports matches as a pulse, LED toggle and counter.
//
//   state (s_q)   | meaning
//   --------------+-----------------------------------------------
//   0             | nothing matched yet
//   k (1..LEN-1)  | pattern[0..k-1] equals the last k characters seen
module fsm_pattern_detect #(
   parameter int                         DATA_W  = 8,
   parameter int                         PAT_LEN = 5,
   parameter logic [PAT_LEN*DATA_W-1:0]  PATTERN = "Hello",
   parameter bit                         OVERLAP = 1'b1,
   parameter int                         CNT_W   = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           data_valid,
   input  logic [DATA_W-1:0]              data,
   input  logic                           clr_cnt,
   output logic                           match,
   output logic                           led,
   output logic [CNT_W-1:0]               match_cnt,
   output logic [$clog2(PAT_LEN+1)-1:0]   progress
);

   localparam int PW = $clog2(PAT_LEN+1);

   typedef logic [PAT_LEN-1:0][PAT_LEN:0] cand_t;

   function automatic logic [DATA_W-1:0] pat_chr(input int i);
      return PATTERN[(PAT_LEN-1-i)*DATA_W +: DATA_W];
   endfunction

   // CAND[s][k]: with s characters matched, pattern[0..k-2] is a suffix of
   // pattern[0..s-1], so length k is reachable if the new character equals pattern[k-1].
   function automatic cand_t calc_cand();
      cand_t t;
      bit    ok;
      t = '0;
      for (int s = 0; s < PAT_LEN; s++) begin
         for (int k = 1; k <= s + 1; k++) begin
            ok = 1'b1;
            for (int i = 0; i < k - 1; i++) begin
               if (pat_chr(i) != pat_chr(s - (k - 1) + i)) ok = 1'b0;
            end
            t[s][k] = ok;
         end
      end
      return t;
   endfunction

   function automatic int calc_border();
      int b;
      bit ok;
      b = 0;
      for (int l = 1; l < PAT_LEN; l++) begin
         ok = 1'b1;
         for (int i = 0; i < l; i++) begin
            if (pat_chr(i) != pat_chr(PAT_LEN - l + i)) ok = 1'b0;
         end
         if (ok) b = l;
      end
      return b;
   endfunction

   localparam cand_t          CAND    = calc_cand();
   localparam int             BORDER  = calc_border();
   localparam logic [PW-1:0]  RESTART = OVERLAP ? PW'(BORDER) : '0;

   logic [PW-1:0]       s_q;
   logic                match_q;
   logic                led_q;
   logic [CNT_W-1:0]    cnt_q;

   logic [PAT_LEN-1:0]  eq;
   logic [PAT_LEN:0]    cand_row;
   logic [PW-1:0]       k_d;
   logic                full_d;

   always_comb begin
      eq = '0;
      for (int j = 0; j < PAT_LEN; j++) begin
         eq[j] = (data == pat_chr(j));
      end
   end

   always_comb begin
      cand_row = '0;
      for (int s = 0; s < PAT_LEN; s++) begin
         if (s_q == PW'(s)) cand_row = CAND[s];
      end
   end

   // Ascending scan: the longest reachable candidate wins.
   always_comb begin
      k_d = '0;
      for (int k = 1; k <= PAT_LEN; k++) begin
         if (cand_row[k] && eq[k-1]) k_d = PW'(k);
      end
      full_d = (k_d == PW'(PAT_LEN));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q     <= '0;
         match_q <= 1'b0;
         led_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         match_q <= 1'b0;
         if (clr_cnt) cnt_q <= '0;
         if (data_valid) begin
            if (full_d) begin
               match_q <= 1'b1;
               led_q   <= ~led_q;
               s_q     <= RESTART;
               if (!clr_cnt && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end else begin
               s_q <= k_d;
            end
         end
      end
   end

   assign match     = match_q;
   assign led       = led_q;
   assign match_cnt = cnt_q;
   assign progress  = s_q;

endmodule

// File: tb/tb_fsm_pattern_detect.sv
// Scoreboard bench for fsm_pattern_detect: five configurations driven with directed strings;
// expected match events are queued at stimulus time and popped by a monitor on each match pulse.
module tb_fsm_pattern_detect;

   typedef struct {
      int id;
      int led;
      int cnt;
      int prog;
      int cyc;
   } exp_t;

   logic clk;
   logic rst_n [5];
   logic vld   [5];
   logic [7:0] dat [5];
   logic clr   [5];

   logic mt [5];
   logic ld [5];
   logic [7:0] cn [5];
   logic [3:0] pg [5];

   logic [7:0] c0, c1, c2;
   logic [1:0] c3;
   logic [7:0] c4;
   logic [2:0] p0, p1, p2, p3;
   logic [1:0] p4;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fsm_pattern_detect u0 (
      .clk(clk), .rst(rst_n[0]), .data_valid(vld[0]), .data(dat[0]), .clr_cnt(clr[0]),
      .match(mt[0]), .led(ld[0]), .match_cnt(c0), .progress(p0));

   fsm_pattern_detect #(.PAT_LEN(4), .PATTERN("abab"), .OVERLAP(1'b1)) u1 (
      .clk(clk), .rst(rst_n[1]), .data_valid(vld[1]), .data(dat[1]), .clr_cnt(clr[1]),
      .match(mt[1]), .led(ld[1]), .match_cnt(c1), .progress(p1));

   fsm_pattern_detect #(.PAT_LEN(4), .PATTERN("abab"), .OVERLAP(1'b0)) u2 (
      .clk(clk), .rst(rst_n[2]), .data_valid(vld[2]), .data(dat[2]), .clr_cnt(clr[2]),
      .match(mt[2]), .led(ld[2]), .match_cnt(c2), .progress(p2));

   fsm_pattern_detect #(.CNT_W(2)) u3 (
      .clk(clk), .rst(rst_n[3]), .data_valid(vld[3]), .data(dat[3]), .clr_cnt(clr[3]),
      .match(mt[3]), .led(ld[3]), .match_cnt(c3), .progress(p3));

   fsm_pattern_detect #(.PAT_LEN(2), .PATTERN("aa"), .OVERLAP(1'b1)) u4 (
      .clk(clk), .rst(rst_n[4]), .data_valid(vld[4]), .data(dat[4]), .clr_cnt(clr[4]),
      .match(mt[4]), .led(ld[4]), .match_cnt(c4), .progress(p4));

   assign cn[0] = c0;
   assign cn[1] = c1;
   assign cn[2] = c2;
   assign cn[3] = {6'b0, c3};
   assign cn[4] = c4;
   assign pg[0] = {1'b0, p0};
   assign pg[1] = {1'b0, p1};
   assign pg[2] = {1'b0, p2};
   assign pg[3] = {1'b0, p3};
   assign pg[4] = {2'b0, p4};

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every match pulse must correspond to the oldest queued expectation.
   always @(negedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (mt[i] === 1'b1) begin
            if (q.size() == 0) begin
               check($sformatf("unexpected_match_dut%0d", i), 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("match_dut_id", i, e.id);
               check($sformatf("match_cycle_dut%0d", i), cyc, e.cyc);
               check($sformatf("match_led_dut%0d", i), int'(ld[i]), e.led);
               check($sformatf("match_cnt_dut%0d", i), int'(cn[i]), e.cnt);
               check($sformatf("match_prog_dut%0d", i), int'(pg[i]), e.prog);
            end
         end
      end
   end

   task automatic put(input int id, input byte ch, input bit clr_i = 1'b0);
      @(negedge clk);
      vld[id] = 1'b1;
      dat[id] = ch;
      clr[id] = clr_i;
   endtask

   task automatic idle(input int id, input bit clr_i = 1'b0);
      @(negedge clk);
      vld[id] = 1'b0;
      clr[id] = clr_i;
   endtask

   task automatic send(input int id, input string s, input bit gaps);
      for (int i = 0; i < s.len(); i++) begin
         put(id, s[i]);
         if (gaps) idle(id);
      end
   endtask

   // Called right after put() of the accepting character: pulse appears one edge later.
   task automatic expect_m(input int id, input int led, input int cnt, input int prog);
      exp_t e;
      e.id = id; e.led = led; e.cnt = cnt; e.prog = prog; e.cyc = cyc + 1;
      q.push_back(e);
   endtask

   task automatic check_state(input string tag, input int id, input int m, input int l,
                              input int c, input int p);
      check({tag, "_match"}, int'(mt[id]), m);
      check({tag, "_led"},   int'(ld[id]), l);
      check({tag, "_cnt"},   int'(cn[id]), c);
      check({tag, "_prog"},  int'(pg[id]), p);
   endtask

   task automatic pulse_reset(input int id);
      @(negedge clk);
      rst_n[id] = 1'b0;
      #1;
      check_state("in_reset", id, 0, 0, 0, 0);
      @(negedge clk);
      rst_n[id] = 1'b1;
   endtask

   initial begin
      int exp_cnt5 [5] = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
         rst_n[i] = 1'b0; vld[i] = 1'b0; dat[i] = 8'h00; clr[i] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) check_state($sformatf("reset_dut%0d", i), i, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) rst_n[i] = 1'b1;

      // Plain "Hello", continuous valid
      send(0, "Hel", 1'b0);
      put(0, "l");
      put(0, "o");
      expect_m(0, 1, 1, 0);
      idle(0);
      check_state("hello_end", 0, 1, 1, 1, 0);
      idle(0);
      check("hello_pulse_one_cycle", int'(mt[0]), 0);

      // Reset clears led/cnt, then "HHelloxHello" with gaps
      pulse_reset(0);
      put(0, "H"); idle(0);
      put(0, "H"); idle(0);
      check("hh_progress", int'(pg[0]), 1);
      send(0, "ell", 1'b1);
      put(0, "o"); expect_m(0, 1, 1, 0); idle(0);
      send(0, "xHell", 1'b1);
      put(0, "o"); expect_m(0, 0, 2, 0); idle(0);
      idle(0);
      check_state("hhello_end", 0, 0, 0, 2, 0);

      // clr_cnt on an idle cycle
      idle(0, 1'b1);
      idle(0);
      check_state("clr_idle", 0, 0, 0, 0, 0);

      // Reset mid-pattern drops the partial match
      send(0, "Hel", 1'b0);
      idle(0);
      check("partial_progress", int'(pg[0]), 3);
      pulse_reset(0);
      send(0, "lo", 1'b0);
      idle(0);
      idle(0);
      check_state("after_reset_lo", 0, 0, 0, 0, 0);

      // "ababab" with and without overlap
      send(1, "aba", 1'b0);
      put(1, "b"); expect_m(1, 1, 1, 2);
      put(1, "a");
      put(1, "b"); expect_m(1, 0, 2, 2);
      idle(1);
      idle(1);
      check_state("abab_ov_end", 1, 0, 0, 2, 2);

      send(2, "aba", 1'b0);
      put(2, "b"); expect_m(2, 1, 1, 0);
      put(2, "a");
      idle(2);
      check("abab_noov_after_a", int'(pg[2]), 1);
      put(2, "b");
      idle(2);
      idle(2);
      check_state("abab_noov_end", 2, 0, 1, 1, 2);

      // Saturating 2-bit counter, then clear coincident with a match
      for (int r = 0; r < 5; r++) begin
         send(3, "Hell", 1'b0);
         put(3, "o");
         expect_m(3, (r % 2 == 0) ? 1 : 0, exp_cnt5[r], 0);
      end
      idle(3);
      check_state("sat_end", 3, 1, 1, 3, 0);
      send(3, "Hell", 1'b0);
      put(3, "o", 1'b1);
      expect_m(3, 0, 0, 0);
      idle(3);
      idle(3);
      check_state("clr_with_match", 3, 0, 0, 0, 0);

      // "aaaa" against "aa": three back-to-back matches
      put(4, "a");
      put(4, "a"); expect_m(4, 1, 1, 1);
      put(4, "a"); expect_m(4, 0, 2, 1);
      put(4, "a"); expect_m(4, 1, 3, 1);
      idle(4);
      idle(4);
      check_state("aa_end", 4, 0, 1, 3, 1);

      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: time limit reached, expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
